// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// The Q-format helpers give a reference for the arithmetic the external MAC performs.
package mac_pkg;

    localparam int unsigned Q_W     = 16;
    localparam int unsigned FRAC_W  = 9;
    localparam int unsigned MAC_LAT = 4;
    localparam int unsigned OP_W    = 2 * Q_W + 1;

    localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] SAT_MIN = 16'h8001;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic           last;
        logic [Q_W-1:0] a;
        logic [Q_W-1:0] b;
    } op_pair_t;

    // Clamp a wide signed value to the symmetric Q6.9 range.
    function automatic logic [Q_W-1:0] q_sat(input logic signed [2*Q_W-1:0] v);
        logic signed [2*Q_W-1:0] hi;
        logic signed [2*Q_W-1:0] lo;
        hi = (2*Q_W)'(signed'(SAT_MAX));
        lo = (2*Q_W)'(signed'(SAT_MIN));
        if (v > hi) return SAT_MAX;
        if (v < lo) return SAT_MIN;
        return v[Q_W-1:0];
    endfunction

    function automatic logic [Q_W-1:0] q_mul(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        logic signed [2*Q_W-1:0] p;
        p = $signed(a) * $signed(b);
        return q_sat(p >>> FRAC_W);
    endfunction

endpackage

// File: rtl/mac_op_fifo.sv
// Synchronous operand-pair FIFO ({last, a, b}) with full/empty flags.
// Read data is presented combinationally from the head entry.
module mac_op_fifo
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: buffers operand pairs, streams them into an external
// pipelined MAC, and captures the accumulator once the last product has landed.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   in_a,
    input  logic [Q_W-1:0]   in_b,
    input  logic             in_last,
    output logic [Q_W-1:0]   mac_a,
    output logic [Q_W-1:0]   mac_b,
    output logic             mac_rst_n,
    input  logic [Q_W-1:0]   mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Q_W-1:0]   res_data,
    output logic [LEN_W-1:0] res_count
);

    localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1);

    op_pair_t         wr_pair;
    op_pair_t         rd_pair;
    logic [OP_W-1:0]  wr_bits;
    logic [OP_W-1:0]  rd_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             run;

    state_t           state;
    state_t           state_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_nx;
    logic [LEN_W-1:0] elem_cnt;
    logic [LEN_W-1:0] elem_cnt_nx;
    logic [Q_W-1:0]   mac_a_nx;
    logic [Q_W-1:0]   mac_b_nx;
    logic             mac_rst_n_nx;
    logic             res_valid_nx;
    logic [Q_W-1:0]   res_data_nx;
    logic [LEN_W-1:0] res_count_nx;

    assign wr_pair  = '{last: in_last, a: in_a, b: in_b};
    assign wr_bits  = wr_pair;
    assign rd_pair  = op_pair_t'(rd_bits);
    // run keeps in_ready low until the first edge after reset.
    assign in_ready = run & ~fifo_full;
    assign push     = in_valid & in_ready;

    mac_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_bits),
        .pop     (pop),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            run       <= 1'b0;
            drain_cnt <= '0;
            elem_cnt  <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_rst_n <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            state     <= state_nx;
            run       <= 1'b1;
            drain_cnt <= drain_cnt_nx;
            elem_cnt  <= elem_cnt_nx;
            mac_a     <= mac_a_nx;
            mac_b     <= mac_b_nx;
            mac_rst_n <= mac_rst_n_nx;
            res_valid <= res_valid_nx;
            res_data  <= res_data_nx;
            res_count <= res_count_nx;
        end
    end

    // Next state plus next values of the registered MAC and result outputs.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        elem_cnt_nx  = elem_cnt;
        mac_a_nx     = '0;
        mac_b_nx     = '0;
        mac_rst_n_nx = 1'b1;
        res_valid_nx = res_valid;
        res_data_nx  = res_data;
        res_count_nx = res_count;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nx     = CLEAR;
                    mac_rst_n_nx = 1'b0;
                end
            end
            CLEAR: begin
                elem_cnt_nx = '0;
                state_nx    = STREAM;
            end
            STREAM: begin
                // An empty FIFO leaves zeros on the MAC inputs: a bubble adds nothing.
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mac_a_nx    = rd_pair.a;
                    mac_b_nx    = rd_pair.b;
                    elem_cnt_nx = (elem_cnt == '1) ? elem_cnt : elem_cnt + LEN_W'(1);
                    if (rd_pair.last) begin
                        state_nx     = DRAIN;
                        drain_cnt_nx = '0;
                    end
                end
            end
            DRAIN: begin
                // Capture once the last product has passed the MAC pipeline.
                if (drain_cnt == DRAIN_W'(MAC_LAT)) begin
                    res_data_nx  = mac_acc;
                    res_count_nx = elem_cnt;
                    res_valid_nx = 1'b1;
                    state_nx     = HOLD;
                end else begin
                    drain_cnt_nx = drain_cnt + DRAIN_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_nx = 1'b0;
                    if (!fifo_empty) begin
                        state_nx     = CLEAR;
                        mac_rst_n_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq with a latency-4 saturating MAC attached.
// Expected results come from a per-vector dot-product model fed by the stimulus.
`timescale 1ns/1ps
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_rst_n;
    logic [15:0] mac_acc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [7:0]  res_count;

    int checks = 0;
    int errors = 0;

    logic [32:0] drv_q[$];
    int          gap_q[$];
    logic [23:0] exp_q[$];

    logic        abort     = 1'b0;
    logic        force_low = 1'b0;
    logic        rnd_ready = 1'b0;
    int          clr_cnt   = 0;
    logic [15:0] m_acc     = 16'h0000;
    int          m_n       = 0;

    always #5 clk = ~clk;

    mac_dot_seq #(
        .FIFO_DEPTH (4),
        .LEN_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_rst_n (mac_rst_n),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Q6.9 arithmetic with symmetric saturation to [-32767, 32767].
    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32767) return 16'h8001;
        return 16'(v);
    endfunction

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return sat16(p >>> 9);
    endfunction

    function automatic logic [15:0] qadd(input logic [15:0] x, input logic [15:0] y);
        return sat16(longint'($signed(x)) + longint'($signed(y)));
    endfunction

    // External MAC: product, two delay stages, then accumulate; sync active-low clear.
    logic [15:0] p0, p1, p2, acc;
    always @(posedge clk) begin
        if (!mac_rst_n) begin
            p0 <= 16'h0; p1 <= 16'h0; p2 <= 16'h0; acc <= 16'h0;
        end else begin
            p0  <= qmul(mac_a, mac_b);
            p1  <= p0;
            p2  <= p1;
            acc <= qadd(acc, p2);
        end
    end
    assign mac_acc = acc;

    task automatic add_pair(input logic [15:0] a, input logic [15:0] b, input logic last, input int gap);
        drv_q.push_back({last, a, b});
        gap_q.push_back(gap);
        m_acc = qadd(m_acc, qmul(a, b));
        if (m_n < 255) m_n++;
        if (last) begin
            exp_q.push_back({8'(m_n), m_acc});
            m_acc = 16'h0;
            m_n   = 0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((drv_q.size() != 0 || exp_q.size() != 0 || in_valid) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  32'(res_data),  32'd0);
        check({tag, "_res_count"}, 32'(res_count), 32'd0);
        check({tag, "_mac_a"},     32'(mac_a),     32'd0);
        check({tag, "_mac_b"},     32'(mac_b),     32'd0);
        check({tag, "_mac_rst_n"}, 32'(mac_rst_n), 32'd0);
    endtask

    // Operand driver: honours per-pair idle gaps and waits for in_ready.
    initial begin : driver
        logic [32:0] item;
        int          gap;
        int          tmo;
        logic        f;
        in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_last = 1'b0;
        forever begin
            if (drv_q.size() == 0 || abort) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                item = drv_q.pop_front();
                gap  = gap_q.pop_front();
                if (gap > 0) begin
                    in_valid = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                end
                if (!abort) begin
                    in_valid = 1'b1;
                    {in_last, in_a, in_b} = item;
                    tmo = 0;
                    f   = 1'b0;
                    while (!f && tmo < 2000 && !abort) begin
                        @(negedge clk);
                        f = in_ready;
                        @(posedge clk); #1;
                        tmo++;
                    end
                    if (!f && !abort) check("push_timeout", 32'(f), 32'd1);
                    in_valid = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_low)      res_ready = 1'b0;
            else if (rnd_ready) res_ready = ($urandom_range(0, 2) != 0);
            else                res_ready = 1'b1;
        end
    end

    // Result monitor: checks captured values on handshake and stability while held.
    initial begin : monitor
        logic        hold_prev;
        logic [23:0] hold_val;
        logic [23:0] e;
        hold_prev = 1'b0;
        hold_val  = 24'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (!mac_rst_n) clr_cnt++;
                if (hold_prev)
                    check("hold_stable", {7'd0, res_valid, res_count, res_data}, {7'd0, 1'b1, hold_val});
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("res_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data",  32'(res_data),  32'(e[15:0]));
                        check("res_count", 32'(res_count), 32'(e[23:16]));
                    end
                    hold_prev = 1'b0;
                end else if (res_valid) begin
                    hold_prev = 1'b1;
                    hold_val  = {res_count, res_data};
                end else begin
                    hold_prev = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   t;
        logic saw_full;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("pre_edge_mac_rst_n", 32'(mac_rst_n), 32'd0);
        check("pre_edge_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        check("post_edge_mac_rst_n", 32'(mac_rst_n), 32'd1);
        check("post_edge_in_ready",  32'(in_ready),  32'd1);

        // Three unit products.
        for (int k = 0; k < 3; k++) add_pair(16'h0200, 16'h0200, k == 2, 0);
        wait_idle("idle_three");
        // Negative single pair.
        add_pair(16'hFE00, 16'h0200, 1'b1, 0);
        wait_idle("idle_neg");
        // Saturating products and sum.
        add_pair(16'h4000, 16'h4000, 1'b0, 0);
        add_pair(16'h4000, 16'h4000, 1'b1, 0);
        wait_idle("idle_sat");
        // Input gap produces uncounted bubbles.
        add_pair(16'h0200, 16'h0200, 1'b0, 0);
        add_pair(16'h0200, 16'h0200, 1'b1, 3);
        wait_idle("idle_gap");

        // Back-to-back vectors with the result held off.
        force_low = 1'b1;
        for (int k = 0; k < 3; k++) add_pair(16'h0100, 16'h0400, k == 2, 0);
        for (int k = 0; k < 5; k++) add_pair(16'h0200, 16'h0100, k == 4, 0);
        t = 0;
        while (!res_valid && t < 500) begin @(negedge clk); t++; end
        check("b2b_res_wait", 32'(res_valid), 32'd1);
        saw_full = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!in_ready) saw_full = 1'b1;
        end
        check("b2b_fifo_full", 32'(saw_full), 32'd1);
        clr_cnt = 0;
        force_low = 1'b0;
        wait_idle("idle_b2b");
        check("b2b_clear_pulses", 32'(clr_cnt), 32'd1);

        // Reset in the middle of streaming.
        for (int k = 0; k < 6; k++) add_pair(16'h0200, 16'h0200, k == 5, 1);
        t = 0;
        while (mac_a == 16'h0 && t < 500) begin @(negedge clk); t++; end
        check("mid_stream_reached", 32'(mac_a), 32'h0200);
        @(posedge clk); #1;
        rst   = 1'b1;
        abort = 1'b1;
        drv_q.delete();
        gap_q.delete();
        exp_q.delete();
        m_acc = 16'h0;
        m_n   = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        abort = 1'b0;
        add_pair(16'h0200, 16'h0200, 1'b1, 0);
        wait_idle("idle_after_rst");

        // Randomized vectors with random result back-pressure.
        rnd_ready = 1'b1;
        for (int v = 0; v < 25; v++) begin
            int          len;
            int          mode;
            int          gap;
            logic [15:0] a;
            logic [15:0] b;
            len  = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0: begin a = 16'($urandom); b = 16'($urandom); end
                    1: begin
                        a = 16'($urandom_range(0, 2047)) - 16'd1024;
                        b = 16'($urandom_range(0, 2047)) - 16'd1024;
                    end
                    default: begin
                        a = 16'($urandom_range(0, 7)) << 9;
                        b = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'hFE00;
                    end
                endcase
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                add_pair(a, b, k == len - 1, gap);
            end
        end
        wait_idle("idle_random");

        // Long vector: element count saturates at all-ones.
        for (int k = 0; k < 260; k++) add_pair(16'h0200, 16'h0001, k == 259, 0);
        wait_idle("idle_long");
        rnd_ready = 1'b0;

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_dot_seq.md
MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the operand FIFO depth in pairs (power of two, at least 2).
REQ-002 Parameter LEN_W, default 8, SHALL set the width of res_count.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 in_valid / in_ready  in / out  1 / 1  SHALL form the operand-pair handshake; a pair transfers on a cycle where both are high.
REQ-006 in_a, in_b  in  16 each  SHALL carry signed Q6.9 operands; 1.0 is 16'h0200.
REQ-007 in_last  in  1  SHALL mark the final pair of a vector.
REQ-008 mac_a, mac_b  out  16 each  SHALL carry the registered operands driven to the MAC A and B inputs.
REQ-009 mac_rst_n  out  1  SHALL be the registered, active-low clear driven to the MAC reset.
REQ-010 mac_acc  in  16  SHALL be the MAC accumulator output.
REQ-011 res_valid / res_ready  out / in  1 / 1  SHALL form the result handshake.
REQ-012 res_data  out  16  SHALL carry the captured dot product.
REQ-013 res_count  out  LEN_W  SHALL carry the number of pairs in the vector, saturating at all-ones.

Function
REQ-014 in_ready SHALL equal not-full of the operand FIFO; a push SHALL never occur when the FIFO is full.
REQ-015 The FSM SHALL have five states: IDLE, CLEAR, STREAM, DRAIN, HOLD.
REQ-016 IDLE: mac_a = mac_b = 0 and mac_rst_n = 1; the FSM SHALL go to CLEAR when the FIFO is non-empty.
REQ-017 CLEAR: mac_rst_n SHALL be low for exactly one clock period, the element count SHALL be zeroed, and the FSM SHALL go to STREAM.
REQ-018 STREAM, FIFO non-empty: the FSM SHALL pop one pair, register it onto mac_a/mac_b, and increment the element count (saturating).
REQ-019 STREAM, FIFO empty: the FSM SHALL drive zeros (a bubble adds exactly 0 to the MAC) and SHALL NOT count.
REQ-020 When the popped pair has last = 1, the FSM SHALL go to DRAIN.
REQ-021 DRAIN: the FSM SHALL drive zeros and capture mac_acc into res_data on the 5th rising edge after the edge that drove the last operand (MAC_LAT = 4, plus 1); res_valid SHALL rise on that same edge, with the FSM moving to HOLD.
REQ-022 HOLD: res_data, res_count and res_valid SHALL stay stable until res_ready is high.
REQ-023 On the HOLD handshake, res_valid SHALL fall and the FSM SHALL go to CLEAR if the FIFO is non-empty, otherwise to IDLE.
REQ-024 FIFO pushes SHALL continue in every state, including a simultaneous push and pop when the FIFO is not full.
REQ-025 The block SHALL be agnostic to the MAC's rounding and saturation behaviour: res_data equals mac_acc at capture.

Reset
REQ-026 While rst is high: FSM = IDLE, FIFO empty, in_ready = 0, res_valid = 0, res_data = 0, res_count = 0, mac_a = mac_b = 0, mac_rst_n = 0.
REQ-027 After rst deasserts, mac_rst_n SHALL go to 1 on the first clock edge and in_ready to 1 on the first clock edge.
REQ-028 rst asserted mid-vector SHALL discard all in-flight pairs and any pending result.

Structure
REQ-029 Package mac_pkg SHALL hold: Q_W = 16, FRAC_W = 9, MAC_LAT = 4, the FSM state enum, and the saturation constants 16'h7FFF and 16'h8001.
REQ-030 The FIFO SHALL be a single sub-module, mac_op_fifo: synchronous, 33 bits wide ({last, a, b}), with full and empty flags.

Verification
REQ-031 Three pairs (16'h0200, 16'h0200), last on the 3rd -> res_data = 16'h0600, res_count = 3.
REQ-032 One pair (16'hFE00, 16'h0200) with last -> res_data = 16'hFE00, res_count = 1.
REQ-033 Two pairs (16'h4000, 16'h4000) -> res_data = 16'h7FFF (product and sum saturate).
REQ-034 Vector of 2 pairs with a 3-cycle in_valid gap between them -> res_data = 16'h0400, res_count = 2; bubbles are not counted.
REQ-035 Back-to-back vectors with res_ready held low 10 cycles -> FIFO fills and in_ready = 0; the second result is independent of the first (exactly one CLEAR pulse between them).
REQ-036 rst pulsed during STREAM -> all outputs return to reset values; a following 1-pair vector (16'h0200, 16'h0200) -> 16'h0200.
